// File: rtl/gl_triangle_assembler.sv
// Triangle-list assembler: stages vertices in groups of three, queues the triangles in a small FIFO,
// and presents the FIFO head to the rasterizer, holding it stable for the whole raster pass.
module gl_triangle_assembler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned VW    = 96
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vtx_valid,
    output logic                   vtx_ready,
    input  logic [VW-1:0]          vtx_data,
    input  logic                   prim_flush,
    output logic                   fifo_ready,
    output logic [VW-1:0]          fifo_out1,
    output logic [VW-1:0]          fifo_out2,
    output logic [VW-1:0]          fifo_out3,
    input  logic                   raster_ready,
    output logic [$clog2(DEPTH):0] tri_count,
    output logic [1:0]             vtx_pending
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        BUSY    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3*VW-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      pend_q, pend_d;
    logic [VW-1:0]   slot0_q, slot1_q;
    logic [3*VW-1:0] out_q;
    logic            rr_q;
    logic            full, empty, done, pop, accept, push, latch;

    always_comb begin
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        done      = (state_q == BUSY) && raster_ready && !rr_q;
        pop       = done;
        // A pop frees a slot in the same cycle, so a third vertex may land even at full.
        vtx_ready = !rst && !prim_flush && ((pend_q != 2'd2) || !full || pop);
        accept    = vtx_valid && vtx_ready;
        push      = accept && (pend_q == 2'd2);
        latch     = (state_q == IDLE) && !empty;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        pend_d = pend_q;
        if (prim_flush) begin
            pend_d = '0;
        end else if (accept) begin
            pend_d = (pend_q == 2'd2) ? 2'd0 : pend_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = PRESENT;
            PRESENT: state_d = BUSY;
            BUSY:    if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_ready  = (state_q == PRESENT);
        fifo_out1   = out_q[3*VW-1 -: VW];
        fifo_out2   = out_q[2*VW-1 -: VW];
        fifo_out3   = out_q[VW-1:0];
        tri_count   = count_q;
        vtx_pending = pend_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pend_q   <= '0;
            slot0_q  <= '0;
            slot1_q  <= '0;
            out_q    <= '0;
            rr_q     <= 1'b0;
        end else begin
            count_q <= count_d;
            pend_q  <= pend_d;
            rr_q    <= raster_ready;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (latch) out_q <= mem_q[rd_ptr_q];
            if (accept && pend_q == 2'd0) slot0_q <= vtx_data;
            if (accept && pend_q == 2'd1) slot1_q <= vtx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {slot0_q, slot1_q, vtx_data};
    end
endmodule

// File: tb/tb_gl_triangle_assembler.sv
// Bench for gl_triangle_assembler: directed scenarios plus a long random run against a queue-based model.
module tb_gl_triangle_assembler;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned VW    = 96;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    typedef logic [3*VW-1:0] tri_t;

    logic          clk = 1'b0;
    logic          rst, vtx_valid, vtx_ready, prim_flush, fifo_ready, raster_ready;
    logic [VW-1:0] vtx_data, fifo_out1, fifo_out2, fifo_out3;
    logic [CW-1:0] tri_count;
    logic [1:0]    vtx_pending;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    gl_triangle_assembler #(.DEPTH(DEPTH), .VW(VW)) dut (
        .clk(clk), .rst(rst), .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
        .vtx_data(vtx_data), .prim_flush(prim_flush), .fifo_ready(fifo_ready),
        .fifo_out1(fifo_out1), .fifo_out2(fifo_out2), .fifo_out3(fifo_out3),
        .raster_ready(raster_ready), .tri_count(tri_count), .vtx_pending(vtx_pending)
    );

    // Reference model: staged vertices, stored triangles (head first), presentation phase
    // (0 waiting for a triangle, 1 strobe cycle, 2 raster pass running), last raster_ready level.
    logic [VW-1:0] m_stage[$];
    tri_t          m_tris[$];
    int            m_phase = 0;
    tri_t          m_out = '0;
    logic          m_prev_rr = 1'b0;
    int            m_pushed = 0;

    logic          exp_vr, exp_fr, obs_vr, obs_fr;
    logic [CW-1:0] exp_cnt, obs_cnt;
    logic [1:0]    exp_pend, obs_pend;
    tri_t          exp_out, obs_out;

    function automatic logic [VW-1:0] rnd_vtx();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    // One clock: drive inputs, predict and sample outputs mid-cycle, then advance the model.
    task automatic cycle(input logic v, input logic [VW-1:0] d, input logic fl,
                         input logic rr, input logic r);
        logic dn, acc;
        vtx_valid = v; vtx_data = d; prim_flush = fl; raster_ready = rr; rst = r;
        @(negedge clk);
        dn       = (m_phase == 2) && rr && !m_prev_rr;
        exp_fr   = (m_phase == 1);
        exp_vr   = !r && !fl && (m_stage.size() < 2 || m_tris.size() < DEPTH || dn);
        exp_cnt  = CW'(m_tris.size());
        exp_pend = 2'(m_stage.size());
        exp_out  = m_out;
        obs_vr   = vtx_ready;
        obs_fr   = fifo_ready;
        obs_cnt  = tri_count;
        obs_pend = vtx_pending;
        obs_out  = {fifo_out1, fifo_out2, fifo_out3};
        acc      = v && exp_vr;
        @(posedge clk);
        if (r) begin
            m_stage.delete(); m_tris.delete();
            m_phase = 0; m_out = '0; m_prev_rr = 1'b0;
        end else begin
            if (m_phase == 0 && m_tris.size() > 0) begin
                m_phase = 1; m_out = m_tris[0];
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (dn) begin
                void'(m_tris.pop_front()); m_phase = 0;
            end
            if (fl) begin
                m_stage.delete();
            end else if (acc) begin
                m_stage.push_back(d);
                if (m_stage.size() == 3) begin
                    m_tris.push_back({m_stage[0], m_stage[1], m_stage[2]});
                    m_stage.delete();
                    m_pushed++;
                end
            end
            m_prev_rr = rr;
        end
        #1;
    endtask

    task automatic drain();
        logic t = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_tris.size() == 0 && m_phase == 0) break;
            cycle(1'b0, '0, 1'b0, t, 1'b0);
            t = ~t;
        end
    endtask

    task automatic test_reset();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        nchk++; if (obs_vr !== 1'b0) begin nfail++; $display("FAIL reset_vtx_ready_in_rst got %b want 0", obs_vr); end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        nchk++; if (obs_cnt !== '0) begin nfail++; $display("FAIL reset_tri_count got %0d want 0", obs_cnt); end
        nchk++; if (obs_pend !== 2'd0) begin nfail++; $display("FAIL reset_pending got %0d want 0", obs_pend); end
        nchk++; if (obs_fr !== 1'b0) begin nfail++; $display("FAIL reset_fifo_ready got %b want 0", obs_fr); end
        nchk++; if (obs_out !== '0) begin nfail++; $display("FAIL reset_out got %h want 0", obs_out); end
        nchk++; if (obs_vr !== 1'b1) begin nfail++; $display("FAIL reset_vtx_ready got %b want 1", obs_vr); end
    endtask

    task automatic test_single();
        logic [VW-1:0] a, b, c;
        a = rnd_vtx(); b = rnd_vtx(); c = rnd_vtx();
        cycle(1'b1, a, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, b, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, c, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        nchk++; if (obs_cnt !== CW'(1)) begin nfail++; $display("FAIL single_count_after_c got %0d want 1", obs_cnt); end
        nchk++; if (obs_fr !== 1'b0) begin nfail++; $display("FAIL single_ready_early got %b want 0", obs_fr); end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        nchk++; if (obs_fr !== 1'b1) begin nfail++; $display("FAIL single_strobe got %b want 1", obs_fr); end
        nchk++; if (obs_out !== {a, b, c}) begin nfail++; $display("FAIL single_out got %h want %h", obs_out, {a, b, c}); end
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        nchk++; if (obs_fr !== 1'b0) begin nfail++; $display("FAIL single_strobe_len got %b want 0", obs_fr); end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        nchk++; if (obs_cnt !== '0) begin nfail++; $display("FAIL single_count_after_pop got %0d want 0", obs_cnt); end
        nchk++; if (obs_out !== {a, b, c}) begin nfail++; $display("FAIL single_out_held got %h want %h", obs_out, {a, b, c}); end
    endtask

    task automatic test_full();
        logic [VW-1:0] v[15];
        int k = 1;
        logic t = 1'b0;
        for (int i = 0; i < 15; i++) v[i] = rnd_vtx();
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, v[i], 1'b0, 1'b0, 1'b0);
            nchk++; if (obs_vr !== 1'b1) begin nfail++; $display("FAIL full_accept_%0d got %b want 1", i, obs_vr); end
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, v[14], 1'b0, 1'b0, 1'b0);
            nchk++; if (obs_vr !== 1'b0) begin nfail++; $display("FAIL full_stall got %b want 0", obs_vr); end
            nchk++; if (obs_cnt !== CW'(4)) begin nfail++; $display("FAIL full_count got %0d want 4", obs_cnt); end
            nchk++; if (obs_pend !== 2'd2) begin nfail++; $display("FAIL full_pending got %0d want 2", obs_pend); end
        end
        cycle(1'b1, v[14], 1'b0, 1'b1, 1'b0);
        nchk++; if (obs_vr !== 1'b1) begin nfail++; $display("FAIL full_pop_accept got %b want 1", obs_vr); end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        nchk++; if (obs_cnt !== CW'(4)) begin nfail++; $display("FAIL full_count_push_pop got %0d want 4", obs_cnt); end
        nchk++; if (obs_pend !== 2'd0) begin nfail++; $display("FAIL full_pending_wrap got %0d want 0", obs_pend); end
        for (int i = 0; i < 200 && k < 5; i++) begin
            cycle(1'b0, '0, 1'b0, t, 1'b0);
            t = ~t;
            if (obs_fr === 1'b1) begin
                nchk++;
                if (obs_out !== {v[3*k], v[3*k+1], v[3*k+2]}) begin
                    nfail++; $display("FAIL full_drain_tri%0d got %h want %h", k, obs_out, {v[3*k], v[3*k+1], v[3*k+2]});
                end
                k++;
            end
        end
        nchk++; if (k != 5) begin nfail++; $display("FAIL full_drain_timeout got %0d want 5", k); end
        drain();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        nchk++; if (obs_cnt !== '0) begin nfail++; $display("FAIL full_empty got %0d want 0", obs_cnt); end
    endtask

    task automatic test_flush();
        logic [VW-1:0] a, b, x, d, e, f;
        int strobes = 0;
        logic t = 1'b0;
        a = rnd_vtx(); b = rnd_vtx(); x = rnd_vtx(); d = rnd_vtx(); e = rnd_vtx(); f = rnd_vtx();
        cycle(1'b1, a, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, b, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, x, 1'b1, 1'b0, 1'b0);
        nchk++; if (obs_vr !== 1'b0) begin nfail++; $display("FAIL flush_vtx_ready got %b want 0", obs_vr); end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        nchk++; if (obs_pend !== 2'd0) begin nfail++; $display("FAIL flush_pending got %0d want 0", obs_pend); end
        cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, e, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, f, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, '0, 1'b0, t, 1'b0);
            t = ~t;
            if (obs_fr === 1'b1) begin
                strobes++;
                nchk++; if (obs_out !== {d, e, f}) begin nfail++; $display("FAIL flush_out got %h want %h", obs_out, {d, e, f}); end
            end
        end
        nchk++; if (strobes != 1) begin nfail++; $display("FAIL flush_strobes got %0d want 1", strobes); end
        nchk++; if (obs_cnt !== '0) begin nfail++; $display("FAIL flush_empty got %0d want 0", obs_cnt); end
    endtask

    task automatic test_rr_held();
        logic [VW-1:0] v[6];
        int strobes = 0;
        for (int i = 0; i < 6; i++) v[i] = rnd_vtx();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, v[i], 1'b0, 1'b1, 1'b0);
            if (obs_fr === 1'b1) strobes++;
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
            if (obs_fr === 1'b1) strobes++;
        end
        nchk++; if (strobes != 1) begin nfail++; $display("FAIL held_strobes got %0d want 1", strobes); end
        nchk++; if (obs_cnt !== CW'(2)) begin nfail++; $display("FAIL held_no_pop got %0d want 2", obs_cnt); end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        nchk++; if (obs_cnt !== CW'(1)) begin nfail++; $display("FAIL held_pop got %0d want 1", obs_cnt); end
        nchk++; if (obs_fr !== 1'b0) begin nfail++; $display("FAIL held_idle_ready got %b want 0", obs_fr); end
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        nchk++; if (obs_fr !== 1'b1) begin nfail++; $display("FAIL held_next_strobe got %b want 1", obs_fr); end
        nchk++; if (obs_out !== {v[3], v[4], v[5]}) begin nfail++; $display("FAIL held_next_out got %h want %h", obs_out, {v[3], v[4], v[5]}); end
        drain();
    endtask

    task automatic test_reset_busy();
        for (int i = 0; i < 10; i++) cycle(1'b1, rnd_vtx(), 1'b0, 1'b0, 1'b0);
        nchk++; if (obs_cnt !== CW'(3)) begin nfail++; $display("FAIL rstbusy_pre_count got %0d want 3", obs_cnt); end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        nchk++; if (obs_vr !== 1'b0) begin nfail++; $display("FAIL rstbusy_vr_in_rst got %b want 0", obs_vr); end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        nchk++; if (obs_cnt !== '0) begin nfail++; $display("FAIL rstbusy_count got %0d want 0", obs_cnt); end
        nchk++; if (obs_fr !== 1'b0) begin nfail++; $display("FAIL rstbusy_ready got %b want 0", obs_fr); end
        nchk++; if (obs_out !== '0) begin nfail++; $display("FAIL rstbusy_out got %h want 0", obs_out); end
        nchk++; if (obs_vr !== 1'b1) begin nfail++; $display("FAIL rstbusy_vtx_ready got %b want 1", obs_vr); end
        nchk++; if (obs_pend !== 2'd0) begin nfail++; $display("FAIL rstbusy_pending got %0d want 0", obs_pend); end
    endtask

    task automatic test_random();
        int base = m_pushed;
        int strobes = 0;
        int cyc = 0;
        logic t = 1'b0;
        logic v, fl, rr;
        while (cyc < 40000) begin
            if (m_pushed - base >= 1000 && m_tris.size() == 0 && m_phase == 0) break;
            if (m_pushed - base < 1000) begin
                v  = ($urandom_range(0, 3) != 0);
                fl = ($urandom_range(0, 63) == 0);
                rr = 1'($urandom_range(0, 1));
            end else begin
                v = 1'b0; fl = 1'b0; rr = t; t = ~t;
            end
            cycle(v, rnd_vtx(), fl, rr, 1'b0);
            cyc++;
            if (obs_fr === 1'b1) strobes++;
            nchk++; if (obs_vr !== exp_vr) begin nfail++; $display("FAIL rand_vtx_ready cyc %0d got %b want %b", cyc, obs_vr, exp_vr); end
            nchk++; if (obs_fr !== exp_fr) begin nfail++; $display("FAIL rand_fifo_ready cyc %0d got %b want %b", cyc, obs_fr, exp_fr); end
            nchk++; if (obs_cnt !== exp_cnt) begin nfail++; $display("FAIL rand_tri_count cyc %0d got %0d want %0d", cyc, obs_cnt, exp_cnt); end
            nchk++; if (obs_pend !== exp_pend) begin nfail++; $display("FAIL rand_pending cyc %0d got %0d want %0d", cyc, obs_pend, exp_pend); end
            nchk++; if (obs_out !== exp_out) begin nfail++; $display("FAIL rand_out cyc %0d got %h want %h", cyc, obs_out, exp_out); end
        end
        nchk++; if (cyc >= 40000) begin nfail++; $display("FAIL rand_timeout got %0d want <40000", cyc); end
        nchk++; if (strobes != m_pushed - base) begin nfail++; $display("FAIL rand_strobes got %0d want %0d", strobes, m_pushed - base); end
    endtask

    initial begin
        rst = 1'b1; vtx_valid = 1'b0; vtx_data = '0; prim_flush = 1'b0; raster_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_full();
        test_flush();
        test_rr_held();
        test_reset_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end
endmodule
